ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 47 ++++
 rtl/ps2_line_sync.sv | 42 ++++
 rtl/ps2_host_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//
// Shared definitions for the PS/2 blocks: the host-transmit FSM state type,
// well-known host command bytes, the device ACK byte, a handful of keyboard
// scancodes used elsewhere in the codebase, and small helpers for parity and
// counter sizing.
// ---------------------------------------------------------------------------
package ps2_pkg;

  // Host-to-device transmit states, in frame order.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5,
    ACK       = 3'd6,
    WAIT_IDLE = 3'd7
  } ps2_state_e;

  // Host command bytes.
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  // Byte a device returns after accepting a command.
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Set-2 scancodes for the cursor keypad.
  localparam logic [7:0] SC_LEFT      = 8'h6B;
  localparam logic [7:0] SC_RIGHT     = 8'h74;
  localparam logic [7:0] SC_UP        = 8'h75;
  localparam logic [7:0] SC_DOWN      = 8'h72;

  // Odd-parity bit: makes the total number of ones over data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Bits needed for a counter that runs 0 .. term-1 (at least one bit).
  function automatic int cnt_width(input int unsigned term);
    return (term > 1) ? $clog2(term) : 1;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
//
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge detector
// on the synchronized level. All flops reset to 1 because an idle PS/2 line
// floats high, so leaving reset never looks like a falling edge.
//
// Ports
//   clk     system clock
//   rst     synchronous active-high reset
//   line_i  raw asynchronous line level
//   level_o synchronized line level
//   fall_o  one-cycle pulse: synchronized level was 1, now 0
// ---------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Sends one command byte from the host to a PS/2 device. The host inhibits
// the clock, issues a request-to-send (data low, clock released), then shifts
// out 8 data bits LSB first, odd parity and a released stop bit on successive
// device-generated falling clock edges, and finally samples the device ACK.
// A frame-wide timeout aborts a stuck transfer.
//
// Handshake: cmd_rdy is high only in IDLE; a command is taken on any cycle
// where cmd_vld & cmd_rdy, cmd_data is latched on that cycle, and cmd_vld is
// ignored at all other times (no queueing).
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   cmd_vld, cmd_data    command byte offer
//   cmd_rdy              block can accept a command this cycle
//   done                 one-cycle pulse: frame acknowledged by device
//   err                  one-cycle pulse: missing ACK or timeout
//   ps2_clk_in/dat_in    raw PS/2 line levels
//   ps2_clk_oe/dat_oe    1 = pull the line low, 0 = release
//   state_dbg            current FSM state, for observation only
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int clk_mhz    = 50,
  parameter int inhibit_us = 100,
  parameter int timeout_ms = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_vld,
  input  logic [7:0] cmd_data,
  output logic       cmd_rdy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output ps2_state_e state_dbg
);

  localparam int unsigned INH_CYCLES = clk_mhz * inhibit_us;
  localparam int unsigned TMO_CYCLES = clk_mhz * 1000 * timeout_ms;
  localparam int          INH_W      = cnt_width(INH_CYCLES);
  localparam int          TMO_W      = cnt_width(TMO_CYCLES);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  // Synchronized PS/2 lines.
  logic clk_level;
  logic clk_fall;
  logic dat_level;
  logic dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2_clk_in),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2_dat_in),
    .level_o (dat_level),
    .fall_o  (dat_fall_unused)
  );

  // State and datapath registers.
  ps2_state_e       state_q, state_d;
  logic [7:0]       data_q,  data_d;
  logic [2:0]       bit_q,   bit_d;
  logic [INH_W-1:0] inh_q,   inh_d;
  logic [TMO_W-1:0] tmo_q,   tmo_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q,   done_d;
  logic             err_q,    err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      bit_q    <= '0;
      inh_q    <= '0;
      tmo_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      bit_q    <= bit_d;
      inh_q    <= inh_d;
      tmo_q    <= tmo_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cmd_rdy = (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    bit_d    = bit_q;
    inh_d    = inh_q;
    tmo_d    = tmo_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    // Frame timer runs from acceptance until the FSM is back in IDLE.
    if (state_q != IDLE) begin
      tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        bit_d    = '0;
        inh_d    = '0;
        tmo_d    = '0;
        if (cmd_vld && cmd_rdy) begin
          data_d   = cmd_data;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end

      // Clock held low for INH_CYCLES cycles counted from acceptance; the
      // clock release and the start bit happen on the same edge.
      INHIBIT: begin
        if (inh_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          state_d  = RTS;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end

      // The first device falling edge already clocks out bit 0, so DATA
      // handles bits 1..7 and the frame spans 11 falling edges in total.
      RTS: begin
        if (clk_fall) begin
          dat_oe_d = ~data_q[0];
          bit_d    = 3'd1;
          state_d  = DATA;
        end
      end

      DATA: begin
        if (clk_fall) begin
          dat_oe_d = ~data_q[bit_q];
          bit_d    = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end

      PARITY: begin
        if (clk_fall) begin
          dat_oe_d = ~odd_parity(data_q);
          state_d  = STOP;
        end
      end

      // Stop bit is the released (high) line.
      STOP: begin
        if (clk_fall) begin
          dat_oe_d = 1'b0;
          state_d  = ACK;
        end
      end

      ACK: begin
        if (clk_fall) begin
          if (dat_level) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (clk_level && dat_level) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout overrides whatever the frame was doing, including a done that
    // would have fired on the same cycle, so done and err never coincide.
    if ((state_q != IDLE) && (tmo_q == TMO_LAST)) begin
      state_d  = IDLE;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b1;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign done       = done_q;
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Main instance runs at a scaled 1 MHz clock so full frames and the timeout
// stay short; a second instance at the default 50 MHz only measures the
// clock-inhibit length. A behavioural PS/2 device clocks at 12.5 kHz, reads
// host bits on rising edges and optionally ACKs.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned CLK_MHZ = 1;
  localparam int unsigned INH_US  = 100;
  localparam int unsigned TMO_MS  = 2;
  localparam int unsigned TMO_CYC = CLK_MHZ * 1000 * TMO_MS;
  localparam int unsigned HALF    = CLK_MHZ * 1000000 / 12500 / 2;
  localparam int unsigned INH50   = 50 * 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cmd_vld, cmd_rdy, done, err, clk_oe, dat_oe;
  logic [7:0] cmd_data;
  ps2_state_e state_dbg;
  logic       dev_clk, dev_dat;
  logic       clk_line, dat_line;
  assign clk_line = dev_clk & ~clk_oe;
  assign dat_line = dev_dat & ~dat_oe;

  logic       rst50, vld50, rdy50, done50, err50, clk_oe50, dat_oe50;
  logic [7:0] data50;
  ps2_state_e st50;
  logic       clk_line50, dat_line50;
  assign clk_line50 = ~clk_oe50;
  assign dat_line50 = ~dat_oe50;

  ps2_host_tx #(.clk_mhz(CLK_MHZ), .inhibit_us(INH_US), .timeout_ms(TMO_MS)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_data(cmd_data), .cmd_rdy(cmd_rdy),
    .done(done), .err(err), .ps2_clk_in(clk_line), .ps2_dat_in(dat_line),
    .ps2_clk_oe(clk_oe), .ps2_dat_oe(dat_oe), .state_dbg(state_dbg)
  );

  ps2_host_tx #(.clk_mhz(50), .inhibit_us(100), .timeout_ms(1)) dut50 (
    .clk(clk), .rst(rst50), .cmd_vld(vld50), .cmd_data(data50), .cmd_rdy(rdy50),
    .done(done50), .err(err50), .ps2_clk_in(clk_line50), .ps2_dat_in(dat_line50),
    .ps2_clk_oe(clk_oe50), .ps2_dat_oe(dat_oe50), .state_dbg(st50)
  );

  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;
  int err_seen = 0;
  int overlap_seen = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    if (err === 1'b1) err_seen++;
    if (done === 1'b1 && err === 1'b1) overlap_seen++;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish within 60000 cycles");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Frame as the device sees it on its rising edges: {stop, parity, data}.
  function automatic logic [9:0] expect_frame(input logic [7:0] b);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  // ---------------- driver tasks ----------------
  // Offers a command, keeps offering a different byte while the host is
  // busy, then plays the device side of the frame. abort_after >= 0 stops
  // right after the device has read that data bit.
  task automatic drive_frame(input logic [7:0] cmd, input bit ack, input int abort_after,
                             output logic rdy_offer, output bit rts_seen, output logic busy_rdy,
                             output logic start_bit, output logic [9:0] rx);
    int n;
    rts_seen  = 1'b0;
    busy_rdy  = 1'b0;
    start_bit = 1'bx;
    rx        = 'x;
    @(negedge clk);
    cmd_data  = cmd;
    cmd_vld   = 1'b1;
    rdy_offer = cmd_rdy;
    @(negedge clk);
    cmd_data = ~cmd;
    for (int i = 0; i < 10; i++) begin
      busy_rdy = busy_rdy | cmd_rdy;
      @(negedge clk);
    end
    cmd_vld = 1'b0;
    n = 0;
    while (!(clk_line && !dat_line) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) return;
    rts_seen  = 1'b1;
    start_bit = dat_line;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k < 10) rx[k] = dat_line;
      dev_clk = 1'b1;
      if (k == abort_after) return;
      if (k == 9 && ack) dev_dat = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    dev_dat = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; rst50 = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (clk_oe !== 1'b0) begin $display("FAIL reset_clk_oe: got %b expected 0", clk_oe); miscompares++; end
    vectors++; if (dat_oe !== 1'b0) begin $display("FAIL reset_dat_oe: got %b expected 0", dat_oe); miscompares++; end
    vectors++; if (done !== 1'b0) begin $display("FAIL reset_done: got %b expected 0", done); miscompares++; end
    vectors++; if (err !== 1'b0) begin $display("FAIL reset_err: got %b expected 0", err); miscompares++; end
    vectors++; if (cmd_rdy !== 1'b1) begin $display("FAIL reset_cmd_rdy: got %b expected 1", cmd_rdy); miscompares++; end
    vectors++; if ({clk_oe50, dat_oe50, rdy50} !== 3'b001) begin
      $display("FAIL reset_dut50: got oe/rdy %b expected 001", {clk_oe50, dat_oe50, rdy50}); miscompares++; end
    rst = 1'b0; rst50 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_inhibit_50mhz();
    int cnt;
    @(negedge clk);
    data50 = CMD_ENABLE;
    vld50  = 1'b1;
    vectors++; if (rdy50 !== 1'b1) begin $display("FAIL inhibit_rdy: got %b expected 1", rdy50); miscompares++; end
    @(negedge clk);
    vld50 = 1'b0;
    cnt = 0;
    while (clk_oe50 === 1'b1 && dat_oe50 === 1'b0 && cnt < INH50 + 100) begin
      @(negedge clk);
      cnt++;
    end
    vectors++; if (cnt != INH50) begin $display("FAIL inhibit_len: got %0d cycles expected %0d", cnt, INH50); miscompares++; end
    vectors++; if ({clk_oe50, dat_oe50} !== 2'b01) begin
      $display("FAIL inhibit_rts: got clk_oe/dat_oe %b expected 01", {clk_oe50, dat_oe50}); miscompares++; end
    rst50 = 1'b1;
    @(negedge clk);
    rst50 = 1'b0;
    vectors++; if ({clk_oe50, dat_oe50} !== 2'b00) begin
      $display("FAIL inhibit_reset: got clk_oe/dat_oe %b expected 00", {clk_oe50, dat_oe50}); miscompares++; end
  endtask

  task automatic test_command(input string tag, input logic [7:0] cmd);
    logic rdy0, busy, st;
    bit rts;
    logic [9:0] rx, exp;
    int d0, e0, n;
    d0 = done_seen; e0 = err_seen;
    exp = expect_frame(cmd);
    drive_frame(cmd, 1'b1, -1, rdy0, rts, busy, st, rx);
    vectors++; if (rdy0 !== 1'b1) begin $display("FAIL %s cmd_rdy_idle: got %b expected 1", tag, rdy0); miscompares++; end
    vectors++; if (!rts) begin $display("FAIL %s rts: no request-to-send within 1000 cycles", tag); miscompares++; return; end
    vectors++; if (st !== 1'b0) begin $display("FAIL %s start_bit: got %b expected 0", tag, st); miscompares++; end
    vectors++; if (rx[7:0] !== exp[7:0]) begin $display("FAIL %s data: got %h expected %h", tag, rx[7:0], exp[7:0]); miscompares++; end
    vectors++; if (rx[8] !== exp[8]) begin $display("FAIL %s parity: got %b expected %b", tag, rx[8], exp[8]); miscompares++; end
    vectors++; if (rx[9] !== 1'b1) begin $display("FAIL %s stop: got %b expected 1", tag, rx[9]); miscompares++; end
    vectors++; if (busy !== 1'b0) begin $display("FAIL %s busy_rdy: got %b expected 0", tag, busy); miscompares++; end
    n = 0;
    while (done_seen == d0 && n < 200) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    vectors++; if (done_seen - d0 != 1) begin $display("FAIL %s done_pulses: got %0d expected 1", tag, done_seen - d0); miscompares++; end
    vectors++; if (err_seen != e0) begin $display("FAIL %s err_pulses: got %0d expected 0", tag, err_seen - e0); miscompares++; end
    vectors++; if ({clk_oe, dat_oe} !== 2'b00) begin $display("FAIL %s lines_after: got %b expected 00", tag, {clk_oe, dat_oe}); miscompares++; end
    vectors++; if (cmd_rdy !== 1'b1) begin $display("FAIL %s rdy_after: got %b expected 1", tag, cmd_rdy); miscompares++; end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) test_command("random", 8'($urandom_range(0, 255)));
  endtask

  task automatic test_nack();
    logic rdy0, busy, st;
    bit rts;
    logic [9:0] rx;
    logic [7:0] cmd;
    int d0, e0, n;
    cmd = 8'($urandom_range(0, 255));
    d0 = done_seen; e0 = err_seen;
    drive_frame(cmd, 1'b0, -1, rdy0, rts, busy, st, rx);
    vectors++; if (!rts) begin $display("FAIL nack rts: no request-to-send within 1000 cycles"); miscompares++; return; end
    vectors++; if (rx[7:0] !== cmd) begin $display("FAIL nack data: got %h expected %h", rx[7:0], cmd); miscompares++; end
    n = 0;
    while (err_seen == e0 && n < 200) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    vectors++; if (err_seen - e0 != 1) begin $display("FAIL nack err_pulses: got %0d expected 1", err_seen - e0); miscompares++; end
    vectors++; if (done_seen != d0) begin $display("FAIL nack done_pulses: got %0d expected 0", done_seen - d0); miscompares++; end
    vectors++; if ({clk_oe, dat_oe} !== 2'b00) begin $display("FAIL nack lines: got %b expected 00", {clk_oe, dat_oe}); miscompares++; end
    vectors++; if (cmd_rdy !== 1'b1) begin $display("FAIL nack cmd_rdy: got %b expected 1", cmd_rdy); miscompares++; end
  endtask

  task automatic test_timeout();
    int cnt, d0;
    d0 = done_seen;
    @(negedge clk);
    cmd_data = CMD_RESET;
    cmd_vld  = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    cnt = 0;
    while (err !== 1'b1 && cnt < TMO_CYC + 100) begin
      @(negedge clk);
      cnt++;
      if (cnt == TMO_CYC / 2) begin
        vectors++; if ({clk_oe, dat_oe} !== 2'b01) begin
          $display("FAIL timeout_rts_hold: got clk_oe/dat_oe %b expected 01", {clk_oe, dat_oe}); miscompares++; end
      end
    end
    vectors++; if (cnt != TMO_CYC) begin $display("FAIL timeout_len: got %0d cycles expected %0d", cnt, TMO_CYC); miscompares++; end
    vectors++; if ({clk_oe, dat_oe} !== 2'b00) begin $display("FAIL timeout_lines: got %b expected 00", {clk_oe, dat_oe}); miscompares++; end
    repeat (5) @(negedge clk);
    vectors++; if (cmd_rdy !== 1'b1) begin $display("FAIL timeout_rdy: got %b expected 1", cmd_rdy); miscompares++; end
    vectors++; if (done_seen != d0) begin $display("FAIL timeout_done: got %0d pulses expected 0", done_seen - d0); miscompares++; end
  endtask

  task automatic test_rst_mid_frame();
    logic rdy0, busy, st;
    bit rts;
    logic [9:0] rx;
    int d0, e0;
    d0 = done_seen; e0 = err_seen;
    drive_frame(CMD_SET_LEDS, 1'b1, 4, rdy0, rts, busy, st, rx);
    vectors++; if (rx[4:0] !== CMD_SET_LEDS[4:0]) begin
      $display("FAIL rst_mid partial_data: got %h expected %h", rx[4:0], CMD_SET_LEDS[4:0]); miscompares++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if ({clk_oe, dat_oe} !== 2'b00) begin $display("FAIL rst_mid lines: got %b expected 00", {clk_oe, dat_oe}); miscompares++; end
    repeat (50) @(negedge clk);
    vectors++; if (done_seen != d0 || err_seen != e0) begin
      $display("FAIL rst_mid pulses: got done %0d err %0d expected 0 0", done_seen - d0, err_seen - e0); miscompares++; end
    vectors++; if (cmd_rdy !== 1'b1) begin $display("FAIL rst_mid rdy: got %b expected 1", cmd_rdy); miscompares++; end
    test_command("after_rst", CMD_ENABLE);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; cmd_vld = 1'b0; cmd_data = 8'h00;
    rst50 = 1'b1; vld50 = 1'b0; data50 = 8'h00;
    dev_clk = 1'b1; dev_dat = 1'b1;
    test_reset();
    test_inhibit_50mhz();
    test_command("set_leds", CMD_SET_LEDS);
    test_command("reset_cmd", CMD_RESET);
    test_random();
    test_nack();
    test_timeout();
    test_rst_mid_frame();
    vectors++; if (overlap_seen != 0) begin
      $display("FAIL done_err_overlap: got %0d cycles with both high expected 0", overlap_seen); miscompares++; end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
